// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter.
// Holds the FSM state encoding and the default bus widths and timeout.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-port, data-port and memory-port signals of the arbiter.
// Modports: slave = arbiter side, master = pipeline/memory environment side.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W_DEF
);

    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_flush_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_ready_o;
    logic              i_stall_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ready_o;
    logic              d_stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              err_o;

    modport slave (
        input  i_req_i, i_addr_i, i_flush_i,
        output i_rdata_o, i_ready_o, i_stall_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_rdata_o, d_ready_o, d_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i,
        output err_o
    );

    modport master (
        output i_req_i, i_addr_i, i_flush_i,
        input  i_rdata_o, i_ready_o, i_stall_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_rdata_o, d_ready_o, d_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// Outstanding-access watchdog: counts busy cycles, flags expiry.
// Ports: clk, rst (sync high), clr (grant), en (access busy), expire.
module arb_timeout_counter #(
    parameter int TIMEOUT = mem_arbiter_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // Expiry is seen in the TIMEOUT-th busy cycle after the grant.
    assign expire = en & (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and
// load/store. Ports: clk_i, rst_i (sync high), bus (mem_arbiter_if.slave).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state;
    logic              discard;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic              i_ready;
    logic              d_ready;
    logic              err;

    logic              d_elig;
    logic              i_elig;
    logic              grant;
    logic              busy;
    logic              tmo_expire;

    // A request still held during its own ready cycle must not re-issue.
    assign d_elig = bus.d_req_i & ~d_ready;
    assign i_elig = bus.i_req_i & ~i_ready;
    assign grant  = (state == S_IDLE) & (d_elig | i_elig);
    assign busy   = (state != S_IDLE) & ~bus.mem_ack_i;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (grant),
        .en     (busy),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            discard   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (d_elig) begin
                        state     <= S_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= bus.d_we_i;
                        mem_addr  <= bus.d_addr_i;
                        mem_wdata <= bus.d_wdata_i;
                    end else if (i_elig) begin
                        state     <= S_INST;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= bus.i_addr_i;
                        mem_wdata <= '0;
                        discard   <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (bus.mem_ack_i) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        d_rdata <= bus.mem_rdata_i;
                        d_ready <= 1'b1;
                    end else if (tmo_expire) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                S_INST: begin
                    if (bus.mem_ack_i) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        // A flush in the ack cycle still kills this fetch.
                        if (!(discard || bus.i_flush_i)) begin
                            i_rdata <= bus.mem_rdata_i;
                            i_ready <= 1'b1;
                        end
                    end else begin
                        if (bus.i_flush_i) begin
                            discard <= 1'b1;
                        end
                        if (tmo_expire) begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.i_rdata_o   = i_rdata;
    assign bus.d_rdata_o   = d_rdata;
    assign bus.i_ready_o   = i_ready;
    assign bus.d_ready_o   = d_ready;
    assign bus.err_o       = err;

    // Stalls track the level request until its ready pulse.
    assign bus.i_stall_o = bus.i_req_i & ~i_ready;
    assign bus.d_stall_o = bus.d_req_i & ~d_ready;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipelined CPU.
- Sequences each access over a req/ack handshake to the memory.
- Returns read data to the requesting stage.
- Generates per-stage stall signals that feed the PC and pipeline-register stall logic alongside the hazard detection unit.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles an access may stay outstanding before an error abort; must be >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset (one clock domain, clk_i).
- i_req_i  in  1  IF fetch request; level, held while i_stall_o=1.
- i_addr_i  in  ADDR_W  fetch address (PC).
- i_flush_i  in  1  branch/jump flush; the pending fetch result is discarded.
- i_rdata_o  out  DATA_W  fetched instruction; valid when i_ready_o=1.
- i_ready_o  out  1  one-cycle pulse, fetch complete.
- i_stall_o  out  1  i_req_i & ~i_ready_o.
- d_req_i  in  1  MEM-stage access request; level, held while d_stall_o=1.
- d_we_i  in  1  1=store, 0=load.
- d_addr_i  in  ADDR_W  data address (EX/MEM ALU result).
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data; valid when d_ready_o=1.
- d_ready_o  out  1  one-cycle pulse, data access complete.
- d_stall_o  out  1  d_req_i & ~d_ready_o.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ack_i  in  1  memory completion, one cycle; read data valid in the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - State goes to IDLE.
  - All registered outputs become 0: mem_*, i_rdata_o, d_rdata_o, i_ready_o, d_ready_o, err_o.
  - Discard flag and timeout counter are cleared.
  - Reset mid-access abandons the access; any later mem_ack_i arriving in IDLE is ignored.
- FSM states: IDLE, DATA, INST.
- IDLE arbitration (fixed priority, data over instruction, so the older instruction always drains first):
  - A requester is eligible only if its req is 1 and its ready is 0 this cycle. This blocks the held request from re-issuing in the cycle the pipeline advances.
  - d eligible: go to DATA. Register mem_req_o=1, mem_we_o=d_we_i, mem_addr_o=d_addr_i, mem_wdata_o=d_wdata_i.
  - else i eligible: go to INST. Register mem_req_o=1, mem_we_o=0, mem_addr_o=i_addr_i, mem_wdata_o=0, discard=0.
  - Grant-to-first-mem_req_o latency: 1 cycle.
- DATA / INST states:
  - mem_* outputs held stable until mem_ack_i.
  - On mem_ack_i: mem_req_o<=0 and state<=IDLE.
  - DATA: d_rdata_o<=mem_rdata_i (loads; updated on stores too, value don't-care) and d_ready_o<=1 next cycle.
  - INST with discard=0: i_rdata_o<=mem_rdata_i and i_ready_o<=1 next cycle.
  - INST with discard=1: no ready pulse and i_rdata_o unchanged; the refetch of the new PC is arbitrated normally from IDLE.
- Flush:
  - i_flush_i in INST (any cycle, including the ack cycle) sets discard.
  - i_flush_i in IDLE or DATA has no effect.
- Best-case access latency: request to ready pulse = 3 cycles with a 1-cycle ack (grant, mem cycle, ready).
- Stalls are combinational:
  - A stage stalls every cycle its request is pending, including while the other stage owns memory.
  - Simultaneous i_req_i and d_req_i: data is served first; IF stalls for both accesses.
- Timeout:
  - A counter increments each cycle in DATA/INST and clears on grant.
  - Reaching TIMEOUT-1 without ack: err_o<=1 (sticky until reset), mem_req_o<=0, state IDLE, no ready pulse.
  - The requester remains stalled and is re-arbitrated.
- mem_ack_i in IDLE is ignored.
- Ready pulses last exactly one cycle.

Decomposition:
- Shared cpu package:
  - FSM state encoding (IDLE=2'd0, DATA=2'd1, INST=2'd2).
  - ADDR_W/DATA_W defaults.
  - TIMEOUT default.
- One natural sub-module: arb_timeout_counter (clear/enable/expire).
- The FSM and mux stay in mem_arbiter.

Test Plan:
- Lone fetch: i_req_i=1, i_addr_i=0x40, memory acks 1 cycle after mem_req_o with 0x8C010004 -> mem_addr_o=0x40, mem_we_o=0, i_ready_o pulses at request+3, i_rdata_o=0x8C010004, i_stall_o=1 for 3 cycles then 0.
- Simultaneous i_req_i (0x44) and d_req_i (store 0x100, data 0xDEADBEEF) -> first memory transaction is write 0x100/0xDEADBEEF, then read 0x44; d_ready_o precedes i_ready_o; no re-grant in either ready cycle.
- Flush during fetch: INST outstanding at 0x48, i_flush_i pulsed, PC changes to 0x80 -> no i_ready_o for 0x48, next transaction reads 0x80, i_rdata_o holds previous value until 0x80 completes.
- Slow memory: ack delayed 10 cycles on load 0x200 -> mem_* stable all 10 cycles, d_stall_o=1 throughout, d_rdata_o matches, err_o=0.
- Timeout: TIMEOUT=8, no ack -> err_o=1 after 8 cycles in DATA, mem_req_o drops, request re-issued from IDLE, err_o stays 1 until rst_i.
- Reset mid-access: rst_i during INST, then late mem_ack_i -> all outputs 0, no ready pulse, state IDLE.
